// File: rtl/opendap_swd_host_serial.sv
// Host-side SWD serialiser: header/write data out, ACK/read data in, one parallel response per request.
// Optional WAIT auto-retry is built when OPENDAP_SWD_HOST_WAIT_RETRY_EN is defined.
module opendap_swd_host_serial #(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned MAX_RETRIES = 8
) (
  input  logic        swclk,
  input  logic        rst_n,
  output logic        swdo,
  output logic        swdo_en,
  input  logic        swdi,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic        req_ap_ndp,
  input  logic        req_r_nw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_parity_err,
  output logic        rsp_protocol_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_TURN_ACK, S_ACK, S_TURN_WD, S_WDATA,
    S_RDATA, S_TURN_RD, S_LRESET, S_TSEL_WAIT, S_SKIP, S_TAIL_IDLE
  } state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;
  localparam logic [5:0] TurnLast  = 6'(TURN_CYCLES - 1);
  localparam logic [5:0] SkipLast  = 6'(32 + TURN_CYCLES);
  localparam logic [5:0] IdleLast  = 6'(IDLE_CYCLES - 1);
  localparam state_e     PostState = (IDLE_CYCLES == 0) ? S_IDLE : S_TAIL_IDLE;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        init_q;
  logic        tsel_q, tsel_d;
  logic        ap_q, ap_d, rnw_q, rnw_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ack_q, ack_d;
  logic [31:0] rd_sh_q, rd_sh_d;
  logic        rd_par_q, rd_par_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_ack_q, rsp_ack_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        perr_q, perr_d, prerr_q, prerr_d;
  logic        swdo_q, swdo_d, swdo_en_q, swdo_en_d;
  logic        accept, retry_pend;
  logic [2:0]  ack_full;
  logic        fin, fin_rd, fin_perr, fin_prerr;
  logic [2:0]  fin_ack;
  logic [7:0]  hdr_bits;

  assign req_ready = (state_q == S_IDLE) && init_q;
  assign accept    = req_ready && req_valid;
  assign ack_full  = {swdi, ack_q[2:1]};

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      init_q      <= 1'b0;
      tsel_q      <= 1'b0;
      ap_q        <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_q       <= '0;
      rd_sh_q     <= '0;
      rd_par_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= '0;
      rsp_rdata_q <= '0;
      perr_q      <= 1'b0;
      prerr_q     <= 1'b0;
      swdo_q      <= 1'b0;
      swdo_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_q      <= 1'b1;
      tsel_q      <= tsel_d;
      ap_q        <= ap_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      rd_sh_q     <= rd_sh_d;
      rd_par_q    <= rd_par_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      perr_q      <= perr_d;
      prerr_q     <= prerr_d;
      swdo_q      <= swdo_d;
      swdo_en_q   <= swdo_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 6'd1;
    tsel_d      = tsel_q;
    ap_d        = ap_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = ack_q;
    rd_sh_d     = rd_sh_q;
    rd_par_d    = rd_par_q;
    rsp_valid_d = 1'b0;
    rsp_ack_d   = rsp_ack_q;
    rsp_rdata_d = rsp_rdata_q;
    perr_d      = perr_q;
    prerr_d     = prerr_q;
    fin         = 1'b0;
    fin_ack     = '0;
    fin_rd      = 1'b0;
    fin_perr    = 1'b0;
    fin_prerr   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          // TARGETSEL is always sent as a DP write to A=11
          tsel_d  = (req_cmd == 2'd2);
          ap_d    = (req_cmd == 2'd2) ? 1'b0  : req_ap_ndp;
          rnw_d   = (req_cmd == 2'd2) ? 1'b0  : req_r_nw;
          addr_d  = (req_cmd == 2'd2) ? 2'b11 : req_addr;
          wdata_d = req_wdata;
          perr_d  = 1'b0;
          prerr_d = 1'b0;
          state_d = (req_cmd == 2'd0 || req_cmd == 2'd2) ? S_HDR : S_LRESET;
        end
      end
      S_HDR: if (cnt_q == 6'd7) begin
        state_d = tsel_q ? S_TSEL_WAIT : S_TURN_ACK;
        cnt_d   = '0;
      end
      S_TURN_ACK: if (cnt_q == TurnLast) begin
        state_d = S_ACK;
        cnt_d   = '0;
      end
      S_ACK: begin
        ack_d = ack_full;
        if (cnt_q == 6'd2) begin
          cnt_d = '0;
          unique case (ack_full)
            ACK_OK:              state_d = rnw_q ? S_RDATA : S_TURN_WD;
            ACK_WAIT, ACK_FAULT: state_d = S_TURN_RD;
            default:             state_d = S_SKIP;
          endcase
        end
      end
      S_TURN_WD: if (cnt_q == TurnLast) begin
        state_d = S_WDATA;
        cnt_d   = '0;
      end
      S_WDATA: if (cnt_q == 6'd32) begin
        fin     = 1'b1;
        fin_ack = tsel_q ? 3'b000 : ack_q;
      end
      S_RDATA: begin
        if (cnt_q == 6'd32) begin
          rd_par_d = swdi;
          state_d  = S_TURN_RD;
          cnt_d    = '0;
        end else begin
          rd_sh_d = {swdi, rd_sh_q[31:1]};
        end
      end
      S_TURN_RD: if (cnt_q == TurnLast) begin
        if (retry_pend) begin
          state_d = (IDLE_CYCLES == 0) ? S_HDR : S_TAIL_IDLE;
          cnt_d   = '0;
        end else begin
          fin      = 1'b1;
          fin_ack  = ack_q;
          fin_rd   = (ack_q == ACK_OK);
          fin_perr = (ack_q == ACK_OK) && (rd_par_q != ^rd_sh_q);
        end
      end
      S_SKIP: if (cnt_q == SkipLast) begin
        fin       = 1'b1;
        fin_ack   = ack_q;
        fin_prerr = 1'b1;
      end
      S_LRESET: if (cnt_q == 6'd57) begin
        fin = 1'b1;
      end
      S_TSEL_WAIT: if (cnt_q == 6'd4) begin
        state_d = S_WDATA;
        cnt_d   = '0;
      end
      S_TAIL_IDLE: if (cnt_q == IdleLast) begin
        state_d = retry_pend ? S_HDR : S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (fin) begin
      state_d     = PostState;
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_ack_d   = fin_ack;
      perr_d      = fin_perr;
      prerr_d     = fin_prerr;
      if (fin_rd) rsp_rdata_d = rd_sh_q;
    end
  end

  // Line value for the slot that starts on the next edge, so the pins stay registered
  always_comb begin
    hdr_bits  = {1'b1, 1'b0, ap_d ^ rnw_d ^ addr_d[0] ^ addr_d[1], addr_d[1], addr_d[0], rnw_d, ap_d, 1'b1};
    swdo_d    = 1'b0;
    swdo_en_d = 1'b0;
    unique case (state_d)
      S_HDR: begin
        swdo_en_d = 1'b1;
        swdo_d    = hdr_bits[cnt_d[2:0]];
      end
      S_WDATA: begin
        swdo_en_d = 1'b1;
        swdo_d    = cnt_d[5] ? ^wdata_d : wdata_d[cnt_d[4:0]];
      end
      S_LRESET: begin
        swdo_en_d = 1'b1;
        swdo_d    = (cnt_d < 6'd56);
      end
      S_TAIL_IDLE: swdo_en_d = 1'b1;
      default: ;
    endcase
  end

`ifdef OPENDAP_SWD_HOST_WAIT_RETRY_EN
  logic [3:0] retry_q, retry_d;
  logic       pend_q, pend_d;

  always_comb begin
    retry_d = retry_q;
    pend_d  = pend_q;
    if (accept) begin
      retry_d = '0;
      pend_d  = 1'b0;
    end else if (state_q == S_ACK && cnt_q == 6'd2 && ack_full == ACK_WAIT &&
                 retry_q < 4'(MAX_RETRIES)) begin
      retry_d = retry_q + 4'd1;
      pend_d  = 1'b1;
    end else if (state_d == S_HDR) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      retry_q <= retry_d;
      pend_q  <= pend_d;
    end
  end

  assign retry_pend = pend_q;
`else
  logic unused_max_retries;
  assign unused_max_retries = |MAX_RETRIES;
  assign retry_pend         = 1'b0;
`endif

  assign swdo             = swdo_q;
  assign swdo_en          = swdo_en_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_ack          = rsp_ack_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_parity_err   = perr_q;
  assign rsp_protocol_err = prerr_q;

endmodule

// File: tb/tb_opendap_swd_host_serial.sv
// Scoreboard bench for opendap_swd_host_serial: per-request slot model of the SWD line plus expected response queue.
module tb_opendap_swd_host_serial;
  localparam int unsigned TC = 2;
  localparam int unsigned IC = 3;
  localparam int unsigned MR = 8;

  logic        swclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        swdi = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_cmd = '0;
  logic        req_ap_ndp = 1'b0;
  logic        req_r_nw = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        swdo, swdo_en, req_ready, rsp_valid, rsp_parity_err, rsp_protocol_err;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  opendap_swd_host_serial #(.TURN_CYCLES(TC), .IDLE_CYCLES(IC), .MAX_RETRIES(MR)) dut (
    .swclk(swclk), .rst_n(rst_n), .swdo(swdo), .swdo_en(swdo_en), .swdi(swdi),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_ap_ndp(req_ap_ndp), .req_r_nw(req_r_nw), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_rdata(rsp_rdata), .rsp_parity_err(rsp_parity_err),
    .rsp_protocol_err(rsp_protocol_err)
  );

  always #5 swclk = ~swclk;

  int unsigned cyc = 0;
  always @(posedge swclk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] rdata;
    logic        perr;
    logic        prerr;
    int unsigned due;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        mon_e;
  logic        q_en[$];
  logic        q_do[$];
  logic        q_di[$];
  logic [2:0]  acks[$];
  logic [31:0] mdl_rdata = '0;
  logic [7:0]  hdr_cap = '0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic put(input logic en, input logic d, input logic di);
    q_en.push_back(en);
    q_do.push_back(d);
    q_di.push_back(di);
  endtask

  task automatic rel(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) put(1'b0, 1'b0, rbit());
  endtask

  task automatic idle_tail();
    for (int unsigned i = 0; i < IC; i++) put(1'b1, 1'b0, rbit());
  endtask

  task automatic hdr(input logic ap, input logic rnw, input logic [1:0] a);
    logic [7:0] h;
    h = {1'b1, 1'b0, ap ^ rnw ^ a[0] ^ a[1], a[1], a[0], rnw, ap, 1'b1};
    for (int i = 0; i < 8; i++) put(1'b1, h[i], rbit());
  endtask

  task automatic wdat(input logic [31:0] d);
    for (int i = 0; i < 32; i++) put(1'b1, d[i], rbit());
    put(1'b1, ^d, rbit());
  endtask

  task automatic rdat(input logic [31:0] d, input logic par);
    for (int i = 0; i < 32; i++) put(1'b0, 1'b0, d[i]);
    put(1'b0, 1'b0, par);
  endtask

  // Builds the expected slot stream from the request, then drives and checks it slot by slot.
  task automatic run_req(input logic [1:0] cmd, input logic ap, input logic rnw,
                         input logic [1:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input logic flip, input int abort_at);
    logic [2:0]  fa, a;
    logic        pe, pr, more, got_en, got_do, want_en, want_do;
    logic [31:0] nrd;
    int unsigned lat, acc, nbad, first, w, k;
    fa = '0; pe = 1'b0; pr = 1'b0; nrd = mdl_rdata; nbad = 0; first = 0; k = 0;
    got_en = 1'b0; got_do = 1'b0; want_en = 1'b0; want_do = 1'b0;
    q_en.delete(); q_do.delete(); q_di.delete();
    if (cmd == 2'd2) begin
      hdr(1'b0, 1'b0, 2'b11);
      rel(5);
      wdat(wd);
    end else if (cmd != 2'd0) begin
      for (int i = 0; i < 56; i++) put(1'b1, 1'b1, rbit());
      put(1'b1, 1'b0, rbit());
      put(1'b1, 1'b0, rbit());
    end else begin
      more = 1'b1;
      while (more) begin
        a = acks[k];
        hdr(ap, rnw, addr);
        rel(TC);
        for (int i = 0; i < 3; i++) put(1'b0, 1'b0, a[i]);
        if (a == 3'b001) begin
          if (rnw) begin
            rdat(rd, ^rd ^ flip);
            rel(TC);
            pe = flip;
            nrd = rd;
          end else begin
            rel(TC);
            wdat(wd);
          end
        end else if (a == 3'b010 || a == 3'b100) begin
          rel(TC);
        end else begin
          rel(33 + TC);
          pr = 1'b1;
        end
        fa = a;
        more = 1'b0;
`ifdef OPENDAP_SWD_HOST_WAIT_RETRY_EN
        if (a == 3'b010 && k < MR) begin
          idle_tail();
          k++;
          more = 1'b1;
        end
`endif
      end
    end
    lat = q_en.size();
    idle_tail();

    w = 0;
    @(negedge swclk);
    while (req_ready !== 1'b1 && w < 300) begin
      @(negedge swclk);
      w++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_timeout", {63'b0, req_ready}, 64'd1);
      return;
    end
    req_cmd = cmd; req_ap_ndp = ap; req_r_nw = rnw; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge swclk);
    #1;
    acc = cyc;
    if (abort_at < 0) sb.push_back('{ack: fa, rdata: nrd, perr: pe, prerr: pr, due: acc + lat});

    for (int unsigned i = 0; i < q_en.size(); i++) begin
      @(negedge swclk);
      if (i == 0) begin
        req_cmd = 2'($urandom_range(0, 3)); req_ap_ndp = rbit(); req_r_nw = rbit();
        req_addr = 2'($urandom_range(0, 3)); req_wdata = $urandom;
      end
      if (i == 5) req_valid = 1'b0;
      if (int'(i) == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_swdo_en", {63'b0, swdo_en}, 64'd0);
        chk("abort_req_ready", {63'b0, req_ready}, 64'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge swclk);
        rst_n = 1'b1;
        mdl_rdata = '0;
        chk("abort_rdata_cleared", {32'b0, rsp_rdata}, 64'd0);
        return;
      end
      swdi = q_di[i];
      if (i < 8) hdr_cap[i] = swdo;
      if (swdo_en !== q_en[i] || (q_en[i] && swdo !== q_do[i]) || req_ready !== 1'b0) begin
        if (nbad == 0) begin
          first = i; got_en = swdo_en; got_do = swdo; want_en = q_en[i]; want_do = q_do[i];
        end
        nbad++;
      end
    end
    vectors++;
    if (nbad != 0) begin
      miscompares++;
      $display("FAIL line_stream: %0d bad slots, first slot %0d got en/do=%b%b expected %b%b",
               nbad, first, got_en, got_do, want_en, want_do);
    end
    mdl_rdata = nrd;
    @(negedge swclk);
    chk("req_ready_after_tail", {63'b0, req_ready}, 64'd1);
  endtask

  always @(negedge swclk) begin
    if (rst_n && rsp_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_cycle", {32'b0, cyc}, {32'b0, mon_e.due});
        chk("rsp_ack", {61'b0, rsp_ack}, {61'b0, mon_e.ack});
        chk("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, mon_e.rdata});
        chk("rsp_parity_err", {63'b0, rsp_parity_err}, {63'b0, mon_e.perr});
        chk("rsp_protocol_err", {63'b0, rsp_protocol_err}, {63'b0, mon_e.prerr});
      end
    end
  end

  initial begin
    logic [1:0]  c;
    logic [2:0]  a;
    int unsigned pick, nw;
    repeat (3) @(negedge swclk);
    chk("reset_swdo", {63'b0, swdo}, 64'd0);
    chk("reset_swdo_en", {63'b0, swdo_en}, 64'd0);
    chk("reset_req_ready", {63'b0, req_ready}, 64'd0);
    chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("reset_rsp_ack", {61'b0, rsp_ack}, 64'd0);
    chk("reset_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
    chk("reset_perr", {63'b0, rsp_parity_err}, 64'd0);
    chk("reset_prerr", {63'b0, rsp_protocol_err}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_first_cycle", {63'b0, req_ready}, 64'd0);
    @(negedge swclk);
    chk("ready_second_cycle", {63'b0, req_ready}, 64'd1);

    acks.delete(); acks.push_back(3'b001);
    run_req(2'd0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0BC12477, 1'b0, -1);
    chk("dpidr_header", {56'b0, hdr_cap}, 64'hA5);
    run_req(2'd0, 1'b1, 1'b0, 2'd1, 32'hDEADBEEF, 32'h0, 1'b0, -1);
    chk("apwrite_header", {56'b0, hdr_cap}, 64'h8B);
    run_req(2'd0, 1'b0, 1'b1, 2'd1, 32'h0, 32'h00000001, 1'b1, -1);
    acks.delete(); acks.push_back(3'b111);
    run_req(2'd0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h12345678, 1'b0, -1);
    run_req(2'd1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, -1);
    run_req(2'd2, 1'b1, 1'b1, 2'd0, 32'h01002927, 32'h0, 1'b0, -1);
    chk("tsel_header", {56'b0, hdr_cap}, 64'h99);
    run_req(2'd3, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, -1);
    acks.delete(); acks.push_back(3'b100);
    run_req(2'd0, 1'b1, 1'b1, 2'd3, 32'h0, 32'hCAFEF00D, 1'b0, -1);
    acks.delete(); acks.push_back(3'b010); acks.push_back(3'b010); acks.push_back(3'b010);
    acks.push_back(3'b001);
    run_req(2'd0, 1'b1, 1'b1, 2'd3, 32'h0, 32'h5A5A0F0F, 1'b0, -1);
    acks.delete();
    for (int i = 0; i < 9; i++) acks.push_back(3'b010);
    acks.push_back(3'b001);
    run_req(2'd0, 1'b0, 1'b0, 2'd1, 32'h13572468, 32'h0, 1'b0, -1);
    acks.delete(); acks.push_back(3'b001);
    run_req(2'd0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h89ABCDEF, 1'b0, 20);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      c = (pick < 7) ? 2'd0 : 2'(pick - 6);
      acks.delete();
      nw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      for (int unsigned j = 0; j < nw; j++) acks.push_back(3'b010);
      case ($urandom_range(0, 5))
        0, 1, 2: a = 3'b001;
        3:       a = 3'b010;
        4:       a = 3'b100;
        default: a = 3'($urandom_range(0, 7));
      endcase
      acks.push_back(a);
      run_req(c, rbit(), rbit(), 2'($urandom_range(0, 3)), $urandom, $urandom,
              ($urandom_range(0, 3) == 0), -1);
    end

    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge swclk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
